// File: rtl/board_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : board_io_pkg
// Purpose  : Shared constants for the board input conditioning slice.
// Revision : 1.0 - initial release
// ============================================================================
package board_io_pkg;

    localparam int          BOARD_IN_WIDTH      = 12;
    localparam int          DEBOUNCE_10MS       = 500000;
    localparam logic [11:0] KEY_ACTIVE_LOW_MASK = 12'hC00;

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One input bit: polarity fix, 2-flop sync, stability counter and
//            sticky rise/fall flags with clear.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic CLOCK_50,
    input  logic HRESETn,
    input  logic raw_in,
    input  logic evt_clr,
    output logic stable,
    output logic rise_evt,
    output logic fall_evt
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_comb begin
        s0_d     = raw_in ^ ACTIVE_LOW;
        s1_d     = s0_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        if (s1_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = s1_q;
            cnt_d    = '0;
            accept   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // A new acceptance overrides a clear arriving on the same edge.
        rise_d = (accept &  s1_q) | (rise_q & ~evt_clr);
        fall_d = (accept & ~s1_q) | (fall_q & ~evt_clr);
    end

    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn) begin
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable   = stable_q;
    assign rise_evt = rise_q;
    assign fall_evt = fall_q;

endmodule
`default_nettype wire

// File: rtl/board_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : board_input_conditioner
// Purpose  : Debounces the slide switches and user keys; sticky edge flags.
// Revision : 1.0 - initial release
// ============================================================================
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int               WIDTH           = BOARD_IN_WIDTH,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter logic [WIDTH-1:0] ACTIVE_LOW_MASK = KEY_ACTIVE_LOW_MASK
) (
    input  logic             CLOCK_50,
    input  logic             HRESETn,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise_evt,
    output logic [WIDTH-1:0] fall_evt,
    output logic             any_evt
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
        ) u_ch (
            .CLOCK_50 (CLOCK_50),
            .HRESETn  (HRESETn),
            .raw_in   (raw_in[i]),
            .evt_clr  (evt_clr[i]),
            .stable   (stable[i]),
            .rise_evt (rise_evt[i]),
            .fall_evt (fall_evt[i])
        );
    end

    assign any_evt = |(rise_evt | fall_evt);

endmodule
`default_nettype wire

// File: tb/tb_board_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_input_conditioner
// Purpose  : Table-driven self-checking bench with an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_input_conditioner;

    localparam int          WIDTH = 12;
    localparam int          DEB   = 4;
    localparam logic [11:0] MASK  = 12'hC00;

    typedef struct {
        logic [11:0] raw;
        logic [11:0] clr;
        int          reps;
        logic [11:0] es;
        logic [11:0] er;
        logic [11:0] ef;
        logic        ea;
        string       name;
    } vec_t;

    typedef struct {
        logic [11:0] es;
        logic [11:0] er;
        logic [11:0] ef;
        logic        ea;
        string       name;
    } exp_t;

    logic        CLOCK_50 = 1'b0;
    logic        HRESETn;
    logic [11:0] raw_in;
    logic [11:0] evt_clr;
    logic [11:0] stable;
    logic [11:0] rise_evt;
    logic [11:0] fall_evt;
    logic        any_evt;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    board_input_conditioner #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW_MASK (MASK)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .HRESETn  (HRESETn),
        .raw_in   (raw_in),
        .evt_clr  (evt_clr),
        .stable   (stable),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt),
        .any_evt  (any_evt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic cmp12(input string name, input string what, input logic [11:0] got, input logic [11:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", name, what, got, want);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: queue empty, got nothing expected an entry");
            return;
        end
        e = exp_q.pop_front();
        cmp12(e.name, "stable",   stable,   e.es);
        cmp12(e.name, "rise_evt", rise_evt, e.er);
        cmp12(e.name, "fall_evt", fall_evt, e.ef);
        cmp12(e.name, "any_evt",  {11'd0, any_evt}, {11'd0, e.ea});
    endtask

    task automatic expect_now(input string name, input logic [11:0] es, input logic [11:0] er,
                              input logic [11:0] ef, input logic ea);
        exp_t e;
        e.es = es; e.er = er; e.ef = ef; e.ea = ea; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic add(input logic [11:0] raw, input logic [11:0] clr, input int reps,
                       input logic [11:0] es, input logic [11:0] er, input logic [11:0] ef,
                       input logic ea, input string name);
        vec_t v;
        v.raw = raw; v.clr = clr; v.reps = reps;
        v.es = es; v.er = er; v.ef = ef; v.ea = ea; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one table slice (inputs change #1 after an edge), check after each edge.
    task automatic run_vecs();
        while (vecs.size() > 0) begin
            vec_t v;
            v = vecs.pop_front();
            for (int r = 0; r < v.reps; r++) begin
                raw_in  = v.raw;
                evt_clr = v.clr;
                expect_now(v.name, v.es, v.er, v.ef, v.ea);
                @(posedge CLOCK_50);
                #1;
                check_pop();
            end
        end
        evt_clr = '0;
    endtask

    initial begin
        HRESETn = 1'b0;
        raw_in  = 12'hFFF;
        evt_clr = 12'h000;
        repeat (2) @(posedge CLOCK_50);
        #1;
        expect_now("reset_hold", 12'h000, 12'h000, 12'h000, 1'b0);
        check_pop();
        HRESETn = 1'b1;

        // Held keys/switches after reset release: accepted on the 6th edge.
        add(12'hFFF, 12'h000, 5, 12'h000, 12'h000, 12'h000, 1'b0, "post_reset_wait");
        add(12'hFFF, 12'h000, 1, 12'h3FF, 12'h3FF, 12'h000, 1'b1, "post_reset_accept");
        add(12'hFFF, 12'h3FF, 1, 12'h3FF, 12'h000, 12'h000, 1'b0, "clear_all_rise");
        add(12'hC00, 12'h000, 5, 12'h3FF, 12'h000, 12'h000, 1'b0, "switches_off_wait");
        add(12'hC00, 12'h000, 1, 12'h000, 12'h000, 12'h3FF, 1'b1, "switches_off_accept");
        add(12'hC00, 12'hFFF, 1, 12'h000, 12'h000, 12'h000, 1'b0, "clear_all_fall");
        // Clean KEY0 press.
        add(12'h800, 12'h000, 5, 12'h000, 12'h000, 12'h000, 1'b0, "press_wait");
        add(12'h800, 12'h000, 1, 12'h400, 12'h400, 12'h000, 1'b1, "press_accept");
        add(12'h800, 12'h400, 1, 12'h400, 12'h000, 12'h000, 1'b0, "press_clear");
        // Three-cycle glitch on SW3 stays one sample short of acceptance.
        add(12'h808, 12'h000, 3, 12'h400, 12'h000, 12'h000, 1'b0, "glitch_high");
        add(12'h800, 12'h000, 6, 12'h400, 12'h000, 12'h000, 1'b0, "glitch_low");
        // SW3 held, then released, then both flags cleared.
        add(12'h808, 12'h000, 5, 12'h400, 12'h000, 12'h000, 1'b0, "sw3_up_wait");
        add(12'h808, 12'h000, 1, 12'h408, 12'h008, 12'h000, 1'b1, "sw3_up_accept");
        add(12'h800, 12'h000, 5, 12'h408, 12'h008, 12'h000, 1'b1, "sw3_down_wait");
        add(12'h800, 12'h000, 1, 12'h400, 12'h008, 12'h008, 1'b1, "sw3_down_accept");
        add(12'h800, 12'h008, 1, 12'h400, 12'h000, 12'h000, 1'b0, "sw3_clear");
        // Clear on the same edge as a 0->1 acceptance: the set wins.
        add(12'h820, 12'h000, 5, 12'h400, 12'h000, 12'h000, 1'b0, "collide_wait");
        add(12'h820, 12'h020, 1, 12'h420, 12'h020, 12'h000, 1'b1, "collide_set_wins");
        // SW7 starts debouncing; reset is applied mid-count below.
        add(12'h8A0, 12'h000, 3, 12'h420, 12'h020, 12'h000, 1'b1, "sw7_partial");
        run_vecs();

        HRESETn = 1'b0;
        #2;
        expect_now("async_reset", 12'h000, 12'h000, 12'h000, 1'b0);
        check_pop();
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        expect_now("reset_mid_debounce", 12'h000, 12'h000, 12'h000, 1'b0);
        check_pop();
        HRESETn = 1'b1;

        add(12'h8A0, 12'h000, 5, 12'h000, 12'h000, 12'h000, 1'b0, "after_reset_wait");
        add(12'h8A0, 12'h000, 1, 12'h4A0, 12'h4A0, 12'h000, 1'b1, "after_reset_accept");
        add(12'h8A0, 12'hFFF, 1, 12'h4A0, 12'h000, 12'h000, 1'b0, "clear_again");
        // Exactly DEB-cycle pulse on SW0: accepted, then released again.
        add(12'h8A1, 12'h000, 4, 12'h4A0, 12'h000, 12'h000, 1'b0, "min_pulse_high");
        add(12'h8A0, 12'h000, 1, 12'h4A0, 12'h000, 12'h000, 1'b0, "min_pulse_wait");
        add(12'h8A0, 12'h000, 1, 12'h4A1, 12'h001, 12'h000, 1'b1, "min_pulse_accept");
        add(12'h8A0, 12'h000, 3, 12'h4A1, 12'h001, 12'h000, 1'b1, "min_pulse_hold");
        add(12'h8A0, 12'h000, 1, 12'h4A0, 12'h001, 12'h001, 1'b1, "min_pulse_fall");
        run_vecs();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
